// File: rtl/bcd_serial_subtractor.sv
// Digit-serial BCD subtractor: A - B one digit per cycle, LSD first.
// A negative intermediate gets a second serial pass (0 - r) to return sign + magnitude.
module bcd_serial_subtractor #(
   parameter int DIGITS = 4
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   input  logic [4*DIGITS-1:0]   a,
   input  logic [4*DIGITS-1:0]   b,
   output logic                  busy,
   output logic                  done,
   output logic [4*DIGITS-1:0]   diff,
   output logic                  neg,
   output logic                  invalid
);
   localparam int W  = 4 * DIGITS;
   localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

   typedef enum logic [1:0] {IDLE, SUB, NEG, DONE} state_t;

   state_t         state;
   logic [W-1:0]   sa, sb, res;
   logic           borrow;
   logic [IW-1:0]  idx;

   logic           any_bad;
   logic [4:0]     t;
   logic [3:0]     dig;
   logic           borrow_nx;
   logic [W-1:0]   res_nx;
   logic           last;

   always_comb begin
      any_bad = 1'b0;
      for (int i = 0; i < DIGITS; i++)
         if (a[4*i +: 4] > 4'd9 || b[4*i +: 4] > 4'd9) any_bad = 1'b1;
   end

   // One digit step; t spans -10..9 so bit 4 is the sign of the 5-bit result.
   always_comb begin
      t         = {1'b0, sa[3:0]} - {1'b0, sb[3:0]} - {4'b0, borrow};
      borrow_nx = t[4];
      dig       = t[4] ? t[3:0] + 4'd10 : t[3:0];
      res_nx    = (res >> 4) | (W'(dig) << (W - 4));
      last      = (idx == IW'(DIGITS - 1));
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= IDLE;
         sa      <= '0;
         sb      <= '0;
         res     <= '0;
         borrow  <= 1'b0;
         idx     <= '0;
         busy    <= 1'b0;
         done    <= 1'b0;
         diff    <= '0;
         neg     <= 1'b0;
         invalid <= 1'b0;
      end else begin
         case (state)
            IDLE: if (start) begin
               sa      <= a;
               sb      <= b;
               res     <= '0;
               borrow  <= 1'b0;
               idx     <= '0;
               diff    <= '0;
               neg     <= 1'b0;
               invalid <= any_bad;
               if (any_bad) begin
                  done  <= 1'b1;
                  state <= DONE;
               end else begin
                  busy  <= 1'b1;
                  state <= SUB;
               end
            end
            SUB, NEG: begin
               sa     <= sa >> 4;
               sb     <= sb >> 4;
               res    <= res_nx;
               borrow <= borrow_nx;
               idx    <= idx + IW'(1);
               if (last) begin
                  if (state == SUB && borrow_nx) begin
                     // Re-run the chain as 0 - intermediate to recover the magnitude.
                     neg    <= 1'b1;
                     sa     <= '0;
                     sb     <= res_nx;
                     res    <= '0;
                     borrow <= 1'b0;
                     idx    <= '0;
                     state  <= NEG;
                  end else begin
                     diff  <= res_nx;
                     busy  <= 1'b0;
                     done  <= 1'b1;
                     state <= DONE;
                  end
               end
            end
            DONE: begin
               done  <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_bcd_serial_subtractor.sv
// Scoreboard bench: driver pushes integer-arithmetic expectations, monitor checks each done pulse.
module tb_bcd_serial_subtractor;
   localparam int D = 4;
   localparam int W = 4 * D;

   typedef struct {
      logic [W-1:0] diff;
      logic         neg;
      logic         inv;
      int           lat;
      int           t0;
   } exp_t;

   logic         clk = 1'b0;
   logic         reset = 1'b1;
   logic         start = 1'b0;
   logic [W-1:0] a = '0, b = '0;
   logic         busy, done, neg, invalid;
   logic [W-1:0] diff;

   exp_t q[$];
   int   cyc = 0;
   int   n_checks = 0;
   int   n_fail = 0;
   int   bcnt = 0;

   bcd_serial_subtractor #(.DIGITS(D)) dut (
      .clk(clk), .reset(reset), .start(start), .a(a), .b(b),
      .busy(busy), .done(done), .diff(diff), .neg(neg), .invalid(invalid)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
      end
   endtask

   // Reference: decode to integers, subtract, re-encode the magnitude.
   function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y);
      exp_t e;
      int   va = 0, vb = 0, m;
      logic bad = 1'b0;
      for (int i = D - 1; i >= 0; i--) begin
         if (x[4*i +: 4] > 9 || y[4*i +: 4] > 9) bad = 1'b1;
         va = va * 10 + int'(x[4*i +: 4]);
         vb = vb * 10 + int'(y[4*i +: 4]);
      end
      e.diff = '0; e.neg = 1'b0; e.inv = bad; e.t0 = 0;
      if (bad) e.lat = 1;
      else begin
         e.neg = (va < vb);
         m     = e.neg ? vb - va : va - vb;
         e.lat = e.neg ? 2 * D + 1 : D + 1;
         for (int i = 0; i < D; i++) begin
            e.diff[4*i +: 4] = 4'(m % 10);
            m = m / 10;
         end
      end
      return e;
   endfunction

   // Monitor: busy-cycle tally and per-done comparison against the queue head.
   always @(negedge clk) begin
      exp_t e;
      if (reset) bcnt = 0;
      else begin
         if (busy) bcnt++;
         if (done) begin
            if (q.size() == 0) chk("spurious_done", 32'd1, 32'd0);
            else begin
               e = q.pop_front();
               chk("diff", 32'(diff), 32'(e.diff));
               chk("neg", 32'(neg), 32'(e.neg));
               chk("invalid", 32'(invalid), 32'(e.inv));
               chk("latency", 32'(cyc - e.t0), 32'(e.lat));
               chk("busy_cycles", 32'(bcnt), 32'(e.lat - 1));
            end
            bcnt = 0;
         end
      end
   end

   task automatic issue(input logic [W-1:0] x, input logic [W-1:0] y);
      exp_t e;
      @(negedge clk);
      a = x; b = y; start = 1'b1;
      e = model(x, y);
      e.t0 = cyc;
      q.push_back(e);
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_done();
      int k = 0;
      while (q.size() != 0 && k < 100) begin
         @(negedge clk);
         k++;
      end
      if (q.size() != 0) begin
         chk("done_timeout", 32'(q.size()), 32'd0);
         q.delete();
      end
   endtask

   task automatic run(input logic [W-1:0] x, input logic [W-1:0] y);
      issue(x, y);
      wait_done();
   endtask

   function automatic logic [W-1:0] rnd_operand();
      logic [W-1:0] v;
      for (int i = 0; i < D; i++)
         v[4*i +: 4] = ($urandom_range(0, 15) == 0) ? 4'($urandom_range(10, 15))
                                                     : 4'($urandom_range(0, 9));
      return v;
   endfunction

   initial begin
      repeat (3) @(negedge clk);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_diff", 32'(diff), 32'd0);
      chk("rst_neg", 32'(neg), 32'd0);
      chk("rst_invalid", 32'(invalid), 32'd0);
      reset = 1'b0;

      run(16'h5231, 16'h1987);
      run(16'h1987, 16'h5231);
      run(16'h0000, 16'h0001);
      run(16'h9999, 16'h9999);
      run(16'h9999, 16'h0000);
      run(16'h12A4, 16'h0001);
      run(16'h0042, 16'h0017);
      chk("invalid_cleared", 32'(invalid), 32'd0);

      // Second start two cycles in must be ignored.
      issue(16'h4000, 16'h0001);
      @(negedge clk);
      a = 16'h0001; b = 16'h9000; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_done();
      repeat (12) @(negedge clk);

      // Reset during the 3rd SUB cycle: no done, outputs cleared.
      issue(16'h7777, 16'h8888);
      @(negedge clk);
      @(negedge clk);
      reset = 1'b1;
      q.delete();
      @(negedge clk);
      chk("midrst_busy", 32'(busy), 32'd0);
      chk("midrst_done", 32'(done), 32'd0);
      chk("midrst_diff", 32'(diff), 32'd0);
      chk("midrst_neg", 32'(neg), 32'd0);
      @(negedge clk);
      reset = 1'b0;
      run(16'h3000, 16'h0999);
      repeat (12) @(negedge clk);

      for (int n = 0; n < 40; n++) run(rnd_operand(), rnd_operand());

      repeat (4) @(negedge clk);
      chk("queue_drained", 32'(q.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/bcd_serial_subtractor.md
# bcd_serial_subtractor

- Digit-serial, multi-digit BCD subtractor; the subtraction-side companion to the team's combinational single-digit BCD adder.
- Accepts two packed BCD operands on a start pulse and computes A − B one digit per cycle, least-significant digit first, with a registered borrow chain.
- A negative result is returned as sign plus magnitude, never as ten's complement; a second serial pass negates the intermediate.
- Sits between operand registers and the 7-segment display path; start/busy/done handshake.

## Interface

Parameters:
- DIGITS, 4, number of BCD digits per operand (≥1)

Ports:
- clk  input  1  rising-edge clock; the only clock
- reset  input  1  synchronous, active-high reset
- start  input  1  request; sampled only in IDLE
- a  input  4*DIGITS  minuend, packed BCD, digit 0 in [3:0]
- b  input  4*DIGITS  subtrahend, packed BCD, digit 0 in [3:0]
- busy  output  1  high while SUB or NEG is active
- done  output  1  one-cycle completion pulse
- diff  output  4*DIGITS  magnitude of A − B, packed BCD
- neg  output  1  1 when A < B
- invalid  output  1  1 when any digit of a or b exceeds 9

## Operation

- **Reset:** state ← IDLE; busy, done, diff, neg, invalid, borrow and digit index ← 0. Reset asserted mid-operation aborts the operation with no done pulse.
- **IDLE:**
  - start=1 latches a and b into internal shift registers, clears borrow and index, and clears diff, neg and invalid.
  - If any latched digit is >9: invalid ← 1, go to DONE. diff stays 0 and neg stays 0.
  - Otherwise go to SUB.
- **SUB** (DIGITS cycles, index 0..DIGITS−1):
  - t = a_i − b_i − borrow, computed in 5-bit signed arithmetic.
  - If t<0: digit ← t+10 and borrow ← 1. Else digit ← t and borrow ← 0.
  - The digit is shifted into result position i.
  - After the last digit:
    - borrow=0 → DONE.
    - borrow=1 → neg ← 1, clear borrow and index, go to NEG.
- **NEG** (DIGITS cycles): converts the ten's-complement intermediate to its magnitude using the same digit step with minuend 0 and subtrahend r_i (0 − r_i − borrow, +10 correction). The final borrow is discarded. Then go to DONE.
- **DONE** (1 cycle):
  - done=1, busy=0; diff is valid.
  - Next state is IDLE.
- **Holding results:** diff, neg and invalid hold their values until the next accepted start.
- **start outside IDLE:** ignored. This includes start in the DONE cycle. There is no queuing.
- **Stable inputs:** a and b may change freely after the start cycle.
- **Zero result:** never reports neg=1. A ten's-complement result of 0 cannot occur with a borrow, because equal operands produce no borrow.

## Timing

- **Reference edge:** start is sampled high in IDLE at edge E0.
- **busy:** high for the cycles following E0 up to and including the last SUB or NEG cycle. It is low in DONE and IDLE.
- **done latency, A ≥ B:** done is high in the cycle after edge E0+DIGITS, i.e. DIGITS+1 cycles after start.
- **done latency, A < B:** done is high after E0+2·DIGITS, i.e. 2·DIGITS+1 cycles.
- **done latency, invalid:** done is high after E0+1, i.e. 1 cycle.
- **diff/neg/invalid:** registered and stable from the done cycle onward. The earliest next start is the cycle after DONE, so back-to-back throughput is DIGITS+2 or 2·DIGITS+2 cycles.
- **Reset on the same edge as start:** reset wins.

## Test plan

- **A ≥ B:** a=16'h5231, b=16'h1987, start for 1 cycle → done 5 cycles later; diff=16'h3244, neg=0, invalid=0; busy high for exactly 4 cycles.
- **A < B, full result:** a=16'h1987, b=16'h5231 → done 9 cycles after start; diff=16'h3244, neg=1.
- **Boundaries:**
  - a=16'h0000, b=16'h0001 → diff=16'h0001, neg=1.
  - a=b=16'h9999 → diff=16'h0000, neg=0, done at 5 cycles.
  - a=16'h9999, b=16'h0000 → diff=16'h9999.
- **Invalid input:** a=16'h12A4, b=16'h0001 → done 1 cycle after start; invalid=1, diff=0, neg=0. The next valid start clears invalid.
- **Start while busy:** pulse start again with new operands 2 cycles into an operation → the original result is delivered at the original time, and exactly one done pulse occurs.
- **Reset mid-operation:** reset in the 3rd SUB cycle → no done; all outputs 0 on the following cycle. A start one cycle after reset deasserts yields a correct result.
